// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one single-port, variable-latency memory between the fetch
//           and data ports, with starvation guard and sticky timeout flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int STARVE_LIM = 3,
    parameter int MAX_WAIT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    // fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    // memory side
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    // pipeline status
    output logic        stall,
    output logic        err
);

    localparam int c_STARVE_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam int c_WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_LIM = c_STARVE_W'(STARVE_LIM);
    localparam logic [c_WAIT_W-1:0]   c_MAX_WAIT   = c_WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [31:0]             r_mem_addr;
    logic [31:0]             r_mem_wdata;
    logic [31:0]             r_i_rdata;
    logic [31:0]             r_d_rdata;
    logic                    r_i_ready;
    logic                    r_d_ready;
    logic                    r_err;
    logic [c_STARVE_W-1:0]   r_starve_cnt;
    logic [c_WAIT_W-1:0]     r_wait_cnt;

    logic w_starved;
    logic w_grant_d;
    logic w_grant_i;
    logic w_timeout;
    logic [31:0] w_cap_data;

    // Data port normally wins (older instruction) unless fetch has been starved.
    assign w_starved  = i_req && (r_starve_cnt == c_STARVE_LIM);
    assign w_grant_d  = (r_state == ST_IDLE) && d_req && !w_starved;
    assign w_grant_i  = (r_state == ST_IDLE) && !w_grant_d && i_req;
    assign w_timeout  = !mem_ack && (r_wait_cnt == c_MAX_WAIT);
    assign w_cap_data = mem_ack ? mem_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_i_rdata    <= 32'h0;
            r_d_rdata    <= 32'h0;
            r_i_ready    <= 1'b0;
            r_d_ready    <= 1'b0;
            r_err        <= 1'b0;
            r_starve_cnt <= '0;
            r_wait_cnt   <= '0;
        end else begin
            if (!i_req) begin
                r_starve_cnt <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= ST_D_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_wait_cnt  <= '0;
                        if (i_req && (r_starve_cnt != c_STARVE_LIM)) begin
                            r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);
                        end
                    end else if (w_grant_i) begin
                        r_state      <= ST_I_BUSY;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= i_addr;
                        r_wait_cnt   <= '0;
                        r_starve_cnt <= '0;
                    end
                end

                ST_I_BUSY, ST_D_BUSY: begin
                    if (mem_ack || w_timeout) begin
                        r_state   <= ST_DONE;
                        r_mem_req <= 1'b0;
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                        if (r_state == ST_I_BUSY) begin
                            r_i_rdata <= w_cap_data;
                            r_i_ready <= 1'b1;
                        end else begin
                            // Stores complete without touching the load-data register.
                            if (!r_mem_we) begin
                                r_d_rdata <= w_cap_data;
                            end
                            r_d_ready <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end

                ST_DONE: begin
                    r_i_ready <= 1'b0;
                    r_d_ready <= 1'b0;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_ready   = r_i_ready;
    assign d_ready   = r_d_ready;
    assign err       = r_err;
    assign stall     = (i_req && !r_i_ready) || (d_req && !r_d_ready);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Directed self-checking bench for mem_port_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_drdata;

    mem_port_arbiter #(.STARVE_LIM(3), .MAX_WAIT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .err       (err)
    );

    always #5 clk = ~clk;

    // advance one clock; inputs driven and outputs sampled 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; mem_rdata = 0; mem_ack = 0;
        cyc(); cyc();
        n_checks++;
        if ({mem_req, mem_we, i_ready, d_ready, err} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, i_ready, d_ready, err});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'h0)
            $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, i_rdata, d_rdata});
        else n_pass++;
        rst = 1'b1;
        cyc();

        // reset in the middle of a data transaction, ack arrives afterwards
        d_req = 1; d_we = 0; d_addr = 32'h10;
        cyc();
        n_checks++;
        if (mem_req !== 1'b1) $display("FAIL rst_mid_grant: mem_req got %b want 1", mem_req);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL rst_async: mem_req got %b want 0", mem_req);
        else n_pass++;
        d_req = 0;
        cyc();
        rst = 1'b1; mem_ack = 1; mem_rdata = 32'hAAAA_5555;
        cyc();
        mem_ack = 0;
        n_checks++;
        if ({d_ready, err, mem_req} !== 3'b000)
            $display("FAIL rst_stale_ack: {d_ready,err,mem_req} got %b want 000", {d_ready, err, mem_req});
        else n_pass++;
        cyc();
        n_checks++;
        if ({d_ready, d_rdata} !== 33'h0)
            $display("FAIL rst_stale_ack2: {d_ready,d_rdata} got %h want 0", {d_ready, d_rdata});
        else n_pass++;
        exp_drdata = 32'h0;
    endtask

    task automatic test_fetch();
        i_req = 1; i_addr = 32'h40;
        cyc();
        n_checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40})
            $display("FAIL fetch_grant: req/we/addr got %b/%b/%h want 1/0/00000040", mem_req, mem_we, mem_addr);
        else n_pass++;
        n_checks++;
        if (stall !== 1'b1) $display("FAIL fetch_stall: got %b want 1", stall);
        else n_pass++;
        mem_ack = 1; mem_rdata = 32'h2008_0005;
        cyc();
        mem_ack = 0;
        n_checks++;
        if ({i_ready, d_ready, i_rdata} !== {1'b1, 1'b0, 32'h2008_0005})
            $display("FAIL fetch_data: i_ready/d_ready/i_rdata got %b/%b/%h want 1/0/20080005", i_ready, d_ready, i_rdata);
        else n_pass++;
        n_checks++;
        if ({mem_req, stall} !== 2'b00) $display("FAIL fetch_done: mem_req/stall got %b want 00", {mem_req, stall});
        else n_pass++;
        i_req = 0;
        cyc();
        n_checks++;
        if (i_ready !== 1'b0) $display("FAIL fetch_pulse: i_ready got %b want 0", i_ready);
        else n_pass++;
    endtask

    task automatic test_conflict();
        i_req = 1; i_addr = 32'h100;
        d_req = 1; d_we = 0; d_addr = 32'h80;
        cyc();
        n_checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h80})
            $display("FAIL conflict_dwins: req/we/addr got %b/%b/%h want 1/0/00000080", mem_req, mem_we, mem_addr);
        else n_pass++;
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        cyc();
        mem_ack = 0; exp_drdata = 32'hDEAD_BEEF;
        n_checks++;
        if ({d_ready, i_ready, d_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF})
            $display("FAIL conflict_dready: d_ready/i_ready/d_rdata got %b/%b/%h want 1/0/deadbeef", d_ready, i_ready, d_rdata);
        else n_pass++;
        n_checks++;
        if (stall !== 1'b1) $display("FAIL conflict_stall: got %b want 1", stall);
        else n_pass++;
        d_req = 0;
        cyc();
        n_checks++;
        if ({d_ready, mem_req, stall} !== 3'b001)
            $display("FAIL conflict_idle: d_ready/mem_req/stall got %b want 001", {d_ready, mem_req, stall});
        else n_pass++;
        cyc();
        n_checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h100})
            $display("FAIL conflict_igrant: req/addr got %b/%h want 1/00000100", mem_req, mem_addr);
        else n_pass++;
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        cyc();
        mem_ack = 0;
        n_checks++;
        if ({i_ready, i_rdata, stall} !== {1'b1, 32'h1234_5678, 1'b0})
            $display("FAIL conflict_iready: i_ready/i_rdata/stall got %b/%h/%b want 1/12345678/0", i_ready, i_rdata, stall);
        else n_pass++;
        i_req = 0;
        cyc();
    endtask

    task automatic test_starvation();
        logic [31:0] want;
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            want = (k == 3) ? 32'h200 : 32'h300 + 32'(k * 4);
            cyc();
            n_checks++;
            if (mem_addr !== want) $display("FAIL starve_grant%0d: mem_addr got %h want %h", k, mem_addr, want);
            else n_pass++;
            mem_ack = 1; mem_rdata = 32'hC0DE_0000 + 32'(k);
            cyc();
            mem_ack = 0;
            if (k == 3) begin
                n_checks++;
                if ({i_ready, d_ready} !== 2'b10) $display("FAIL starve_iready: i/d ready got %b want 10", {i_ready, d_ready});
                else n_pass++;
                i_req = 0;
            end else begin
                exp_drdata = 32'hC0DE_0000 + 32'(k);
                n_checks++;
                if ({i_ready, d_ready, d_rdata} !== {2'b01, exp_drdata})
                    $display("FAIL starve_dready%0d: ready/d_rdata got %b/%h want 01/%h", k, {i_ready, d_ready}, d_rdata, exp_drdata);
                else n_pass++;
                if (k < 2) d_addr = d_addr + 32'h4;
            end
            cyc();
        end
        // pending data request is served once fetch is done
        cyc();
        n_checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h308})
            $display("FAIL starve_dresume: req/addr got %b/%h want 1/00000308", mem_req, mem_addr);
        else n_pass++;
        mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        cyc();
        mem_ack = 0; exp_drdata = 32'h0BAD_F00D; d_req = 0;
        cyc();
    endtask

    task automatic test_store();
        d_req = 1; d_we = 1; d_addr = 32'h54; d_wdata = 32'h7;
        cyc();
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h54, 32'h7})
            $display("FAIL store_mem: req/we/addr/wdata got %b/%b/%h/%h want 1/1/00000054/00000007", mem_req, mem_we, mem_addr, mem_wdata);
        else n_pass++;
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        cyc();
        mem_ack = 0;
        n_checks++;
        if ({d_ready, d_rdata} !== {1'b1, exp_drdata})
            $display("FAIL store_rdata: d_ready/d_rdata got %b/%h want 1/%h", d_ready, d_rdata, exp_drdata);
        else n_pass++;
        d_req = 0; d_we = 0;
        cyc();
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        d_req = 1; d_we = 1; d_addr = 32'h60; d_wdata = 32'h55;
        cyc();
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            cyc();
            n++;
            if (d_ready) seen = 1;
            else if (n == 10) begin
                n_checks++;
                if ({err, mem_req} !== 2'b01) $display("FAIL timeout_early: err/mem_req got %b want 01", {err, mem_req});
                else n_pass++;
            end
        end
        n_checks++;
        if (!seen || n < 15 || n > 16) $display("FAIL timeout_latency: cycles got %0d (seen=%0d) want 15..16", n, seen);
        else n_pass++;
        n_checks++;
        if ({err, mem_req} !== 2'b10) $display("FAIL timeout_err: err/mem_req got %b want 10", {err, mem_req});
        else n_pass++;
        d_req = 0; d_we = 0;
        cyc(); cyc(); cyc();
        n_checks++;
        if ({err, d_ready} !== 2'b10) $display("FAIL timeout_sticky: err/d_ready got %b want 10", {err, d_ready});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b0) $display("FAIL timeout_clear: err got %b want 0", err);
        else n_pass++;
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_conflict();
        test_starvation();
        test_store();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
